otter_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage OTTER MCU. It replaces the hard-wired `PC_WRITE=1` / `IF_ID_Write=1` with generated stall and flush controls. It produces EX-stage operand forwarding selects, and it freezes the pipeline while a multi-cycle data-memory/IOBUS access is outstanding. Three saturating performance counters record stall, flush and wait activity.

---
 rtl/otter_hazard_ctrl_if.sv | 33 +++
 rtl/otter_hazard_ctrl.sv | 55 +++++
 tb/tb_otter_hazard_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/otter_hazard_ctrl_if.sv
// otter_hazard_ctrl_if: pipeline hazard signals between the OTTER datapath and its hazard controller
interface otter_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] IF_ID_RS1, IF_ID_RS2;
  logic IF_ID_USES_RS1, IF_ID_USES_RS2;
  logic [4:0] ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
  logic ID_EX_MEMREAD2;
  logic [1:0] EX_PCSOURCE;
  logic [4:0] EX_MEM_RD;
  logic EX_MEM_REGWRITE;
  logic [4:0] MEM_WB_RD;
  logic MEM_WB_REGWRITE;
  logic MEM_REQ, MEM_READY;
  logic PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE;
  logic IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT, WAIT_CNT;
  modport master (
    output IF_ID_RS1, IF_ID_RS2, IF_ID_USES_RS1, IF_ID_USES_RS2,
    output ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_MEMREAD2, EX_PCSOURCE,
    output EX_MEM_RD, EX_MEM_REGWRITE, MEM_WB_RD, MEM_WB_REGWRITE, MEM_REQ, MEM_READY,
    input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    input  IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, FWD_A_SEL, FWD_B_SEL,
    input  STALL_CNT, FLUSH_CNT, WAIT_CNT
  );
  modport slave (
    input  IF_ID_RS1, IF_ID_RS2, IF_ID_USES_RS1, IF_ID_USES_RS2,
    input  ID_EX_RS1, ID_EX_RS2, ID_EX_RD, ID_EX_MEMREAD2, EX_PCSOURCE,
    input  EX_MEM_RD, EX_MEM_REGWRITE, MEM_WB_RD, MEM_WB_REGWRITE, MEM_REQ, MEM_READY,
    output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    output IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, FWD_A_SEL, FWD_B_SEL,
    output STALL_CNT, FLUSH_CNT, WAIT_CNT
  );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: stall/flush/freeze control, EX forwarding selects and perf counters for the OTTER pipeline
module otter_hazard_ctrl #(parameter int CNT_W = 16) (
  input logic CLOCK,
  input logic RESET,
  otter_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {S_INIT, S_RUN, S_WAIT} state_t;
  state_t state, state_nxt;
  logic run, freeze, redirect, load_use, ld_hit;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  always_ff @(posedge CLOCK)
    if (RESET) state <= S_INIT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == S_INIT ? S_RUN :
                state == S_WAIT ? (hz.MEM_READY ? S_RUN : S_WAIT) :
                (hz.MEM_REQ && !hz.MEM_READY) ? S_WAIT : S_RUN;
  end
  assign ld_hit = hz.ID_EX_MEMREAD2 && hz.ID_EX_RD != 5'd0 &&
                  ((hz.IF_ID_USES_RS1 && hz.IF_ID_RS1 == hz.ID_EX_RD) ||
                   (hz.IF_ID_USES_RS2 && hz.IF_ID_RS2 == hz.ID_EX_RD));
  always_comb begin
    run      = state != S_INIT;
    freeze   = run && hz.MEM_REQ && !hz.MEM_READY;
    redirect = run && !freeze && hz.EX_PCSOURCE != 2'd0;
    load_use = run && !freeze && !redirect && ld_hit;
    hz.PC_WRITE     = run && !freeze && !load_use;
    hz.IF_ID_WRITE  = !freeze && !load_use;
    hz.ID_EX_WRITE  = !freeze;
    hz.EX_MEM_WRITE = !freeze;
    hz.IF_ID_FLUSH  = !run || redirect;
    hz.ID_EX_FLUSH  = !run || redirect || load_use;
    hz.MEM_WB_FLUSH = freeze;
  end
  always_comb begin
    hz.FWD_A_SEL = (hz.EX_MEM_REGWRITE && hz.EX_MEM_RD != 5'd0 && hz.EX_MEM_RD == hz.ID_EX_RS1) ? 2'b01 :
                   (hz.MEM_WB_REGWRITE && hz.MEM_WB_RD != 5'd0 && hz.MEM_WB_RD == hz.ID_EX_RS1) ? 2'b10 : 2'b00;
    hz.FWD_B_SEL = (hz.EX_MEM_REGWRITE && hz.EX_MEM_RD != 5'd0 && hz.EX_MEM_RD == hz.ID_EX_RS2) ? 2'b01 :
                   (hz.MEM_WB_REGWRITE && hz.MEM_WB_RD != 5'd0 && hz.MEM_WB_RD == hz.ID_EX_RS2) ? 2'b10 : 2'b00;
  end
  // counters saturate at all-ones rather than wrapping
  always_ff @(posedge CLOCK)
    if (RESET) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (load_use && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (freeze && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
    end
  assign hz.STALL_CNT = stall_cnt;
  assign hz.FLUSH_CNT = flush_cnt;
  assign hz.WAIT_CNT  = wait_cnt;
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// tb_otter_hazard_ctrl: directed vectors with hand-computed expectations for otter_hazard_ctrl
module tb_otter_hazard_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  otter_hazard_ctrl_if #(.CNT_W(CW)) hz ();
  otter_hazard_ctrl #(.CNT_W(CW)) dut (.CLOCK(clk), .RESET(rst), .hz(hz));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle();
    hz.IF_ID_RS1 = 0; hz.IF_ID_RS2 = 0; hz.IF_ID_USES_RS1 = 0; hz.IF_ID_USES_RS2 = 0;
    hz.ID_EX_RS1 = 0; hz.ID_EX_RS2 = 0; hz.ID_EX_RD = 0; hz.ID_EX_MEMREAD2 = 0;
    hz.EX_PCSOURCE = 0; hz.EX_MEM_RD = 0; hz.EX_MEM_REGWRITE = 0;
    hz.MEM_WB_RD = 0; hz.MEM_WB_REGWRITE = 0; hz.MEM_REQ = 0; hz.MEM_READY = 0;
  endtask
  task automatic load_use();
    hz.ID_EX_RD = 5; hz.ID_EX_MEMREAD2 = 1; hz.IF_ID_RS1 = 5; hz.IF_ID_USES_RS1 = 1;
    hz.IF_ID_RS2 = 7; hz.IF_ID_USES_RS2 = 1;
  endtask
  task automatic next();
    @(posedge clk); #1;
  endtask
  task automatic frozen(input string tag);
    #2;
    chk({tag, " pc_write"}, hz.PC_WRITE, 0);
    chk({tag, " wr_all"}, {hz.IF_ID_WRITE, hz.ID_EX_WRITE, hz.EX_MEM_WRITE}, 0);
    chk({tag, " flushes"}, {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b001);
  endtask
  initial begin
    idle();
    rst = 1;
    next(); next();
    rst = 0; #2;
    chk("init pc_write", hz.PC_WRITE, 0);
    chk("init flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b110);
    chk("init writes", {hz.IF_ID_WRITE, hz.ID_EX_WRITE, hz.EX_MEM_WRITE}, 3'b111);
    chk("init cnts", {hz.STALL_CNT, hz.FLUSH_CNT, hz.WAIT_CNT}, 0);
    next(); #2;
    chk("run pc_write", hz.PC_WRITE, 1);
    chk("run flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 0);
    chk("run cnts", {hz.STALL_CNT, hz.FLUSH_CNT, hz.WAIT_CNT}, 0);
    next(); hz.ID_EX_RD = 5; hz.ID_EX_MEMREAD2 = 1; hz.IF_ID_RS1 = 5; #2;
    chk("unused rs no stall", hz.PC_WRITE, 1);
    next(); load_use(); #2;
    chk("lu pc_write", hz.PC_WRITE, 0);
    chk("lu if_id_write", hz.IF_ID_WRITE, 0);
    chk("lu flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b010);
    chk("lu ex writes", {hz.ID_EX_WRITE, hz.EX_MEM_WRITE}, 2'b11);
    next(); idle(); hz.ID_EX_RS1 = 5; hz.ID_EX_RD = 6; hz.MEM_WB_RD = 5; hz.MEM_WB_REGWRITE = 1; #2;
    chk("lu stall_cnt", hz.STALL_CNT, 1);
    chk("lu fwd_a wb", hz.FWD_A_SEL, 2'b10);
    chk("lu released", hz.PC_WRITE, 1);
    next(); idle();
    hz.ID_EX_RS1 = 3; hz.ID_EX_RS2 = 3; hz.EX_MEM_RD = 3; hz.MEM_WB_RD = 3;
    hz.EX_MEM_REGWRITE = 1; hz.MEM_WB_REGWRITE = 1; #2;
    chk("fwd_a prio", hz.FWD_A_SEL, 2'b01);
    chk("fwd_b prio", hz.FWD_B_SEL, 2'b01);
    hz.EX_MEM_REGWRITE = 0; #1;
    chk("fwd_a wb only", hz.FWD_A_SEL, 2'b10);
    hz.EX_MEM_REGWRITE = 1; hz.ID_EX_RS1 = 0; hz.ID_EX_RS2 = 0; hz.EX_MEM_RD = 0; hz.MEM_WB_RD = 0; #1;
    chk("fwd x0", {hz.FWD_A_SEL, hz.FWD_B_SEL}, 0);
    next(); idle(); load_use(); hz.EX_PCSOURCE = 2; #2;
    chk("br flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b110);
    chk("br pc_write", hz.PC_WRITE, 1);
    chk("br if_id_write", hz.IF_ID_WRITE, 1);
    next(); idle(); #2;
    chk("br flush_cnt", hz.FLUSH_CNT, 1);
    chk("br stall_cnt", hz.STALL_CNT, 1);
    for (int i = 0; i < 3; i++) begin
      next(); hz.MEM_REQ = 1; hz.MEM_READY = 0; hz.EX_PCSOURCE = 1;
      frozen($sformatf("wait%0d", i));
    end
    next(); hz.MEM_READY = 1; #2;
    chk("rel wait_cnt", hz.WAIT_CNT, 3);
    chk("rel flush_cnt", hz.FLUSH_CNT, 1);
    chk("rel flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b110);
    chk("rel pc_write", hz.PC_WRITE, 1);
    next(); hz.EX_PCSOURCE = 0; hz.MEM_READY = 0;
    frozen("b2b");
    chk("b2b flush_cnt", hz.FLUSH_CNT, 2);
    next(); hz.MEM_READY = 1; #2;
    chk("b2b wait_cnt", hz.WAIT_CNT, 4);
    chk("b2b rel", hz.PC_WRITE, 1);
    next(); idle(); load_use();
    for (int i = 0; i < 20; i++) next();
    idle(); #2;
    chk("sat stall_cnt", hz.STALL_CNT, 15);
    next(); hz.MEM_REQ = 1; hz.MEM_READY = 0;
    next(); rst = 1;
    next(); rst = 0; #2;
    chk("rst init pc_write", hz.PC_WRITE, 0);
    chk("rst init flushes", {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.MEM_WB_FLUSH}, 3'b110);
    chk("rst cnts", {hz.STALL_CNT, hz.FLUSH_CNT, hz.WAIT_CNT}, 0);
    next(); idle(); #2;
    chk("rst run", hz.PC_WRITE, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
